tmds_lane_stage: RTL and testbench

Parametrised TMDS output lane stage between the DVI encoder and the per-lane OSER serializers. It owns the link start-up sequence: serializer reset hold, then a training period of fixed clock/control-token patterns, then live data. It also provides per-lane bit-slip rotation, polarity inversion and idle-token substitution when encoder data is missing. Lane 0 is the TMDS clock lane; lanes 1..NUM_LANES-1 are data lanes.

---
 rtl/tmds_lane_stage.sv | 205 ++++++++++++++++++++
 tb/tb_tmds_lane_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_lane_stage.sv
// -----------------------------------------------------------------------------
// tmds_lane_stage
//
// TMDS output lane stage between the DVI encoder and the per-lane serializers.
// It runs the link start-up sequence and prepares the word sent to each lane:
//   HOLD  : serializers held in reset, all lanes driven with zero
//   TRAIN : clock lane carries CLOCK_PATTERN, data lanes carry IDLE_TOKEN
//   RUN   : encoder words pass through; a missing word (in_valid low) is
//           replaced by the training words and the sticky underflow flag is set
// In TRAIN and RUN every lane word is first rotated by that lane's bit-slip
// count and then optionally inverted. Lane 0 is the TMDS clock lane.
//
// Optional feature macro: TMDS_LANE_STAGE_SLIP_EN
//   defined   : per-lane slip counters and rotation are built
//   undefined : no slip registers, slip_req/slip_lane ignored, no rotation
//
// Ports
//   clock       in   stage (pixel) clock
//   reset_n     in   synchronous active-low reset, priority over all inputs
//   pll_locked  in   combined PLL lock; low forces HOLD
//   in_words    in   encoder words, lane k at [k*WORD_WIDTH +: WORD_WIDTH]
//   in_valid    in   in_words valid this cycle
//   slip_req    in   advance the slip count of slip_lane by one bit
//   slip_lane   in   lane index for slip_req (out-of-range values ignored)
//   invert      in   per-lane polarity inversion
//   out_words   out  words to serializers, same packing as in_words
//   ser_reset   out  active-high serializer reset
//   link_up     out  high while in RUN
//   underflow   out  sticky: in_valid was low at least once in RUN
// -----------------------------------------------------------------------------
module tmds_lane_stage #(
  parameter int NUM_LANES    = 4,
  parameter int WORD_WIDTH   = 10,
  parameter int HOLD_CYCLES  = 16,
  parameter int TRAIN_CYCLES = 1024,
  parameter logic [WORD_WIDTH-1:0] CLOCK_PATTERN = 10'b0000011111,
  parameter logic [WORD_WIDTH-1:0] IDLE_TOKEN    = 10'b1101010100
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            pll_locked,
  input  logic [NUM_LANES*WORD_WIDTH-1:0] in_words,
  input  logic                            in_valid,
  input  logic                            slip_req,
  input  logic [$clog2(NUM_LANES)-1:0]    slip_lane,
  input  logic [NUM_LANES-1:0]            invert,
  output logic [NUM_LANES*WORD_WIDTH-1:0] out_words,
  output logic                            ser_reset,
  output logic                            link_up,
  output logic                            underflow
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > TRAIN_CYCLES) ? HOLD_CYCLES : TRAIN_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                          state_reg, state_next;
  logic [CW-1:0]                   count_reg, count_next;
  logic [NUM_LANES*WORD_WIDTH-1:0] words_reg, words_next;
  logic                            ser_reset_reg;
  logic                            link_up_reg;
  logic                            underflow_reg, underflow_next;

  // Live data is selected only when the stage will be in RUN after this edge;
  // otherwise the lane falls back to its training word.
  logic use_live;
  assign use_live = (state_next == ST_RUN) && in_valid;

  // ---------------------------------------------------------------------------
  // Sequencer: next state and counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    underflow_next = underflow_reg;

    if (!pll_locked) begin
      // Lock loss from any state restarts the whole sequence.
      state_next = ST_HOLD;
      count_next = '0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (count_reg == HOLD_LAST) begin
            state_next = ST_TRAIN;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
        ST_TRAIN: begin
          if (count_reg == TRAIN_LAST) begin
            state_next = ST_RUN;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
        ST_RUN: begin
          count_next = '0;
        end
        default: begin
          state_next = ST_HOLD;
          count_next = '0;
        end
      endcase
    end

    if ((state_next == ST_RUN) && !in_valid) begin
      underflow_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane word selection, rotation and inversion
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : lane_g
      logic [WORD_WIDTH-1:0] base_word;
      logic [WORD_WIDTH-1:0] sel_word;
      logic [WORD_WIDTH-1:0] rot_word;
      logic [WORD_WIDTH-1:0] proc_word;

      if (gi == 0) begin : clk_lane_g
        assign base_word = CLOCK_PATTERN;
      end else begin : data_lane_g
        assign base_word = IDLE_TOKEN;
      end

      assign sel_word = use_live ? in_words[gi*WORD_WIDTH +: WORD_WIDTH] : base_word;

`ifdef TMDS_LANE_STAGE_SLIP_EN
      localparam int SW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
      localparam logic [SW-1:0] SLIP_LAST = SW'(WORD_WIDTH - 1);

      logic [SW-1:0] slip_reg;

      // Slip counts survive lock loss; only reset_n clears them.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          slip_reg <= '0;
        end else if (slip_req && (int'(slip_lane) == gi)) begin
          slip_reg <= (slip_reg == SLIP_LAST) ? '0 : slip_reg + SW'(1);
        end
      end

      // out[i] = w[(i + s) mod WORD_WIDTH]
      always_comb begin
        rot_word = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
          rot_word[i] = sel_word[(i + int'(slip_reg)) % WORD_WIDTH];
        end
      end
`else
      assign rot_word = sel_word;
`endif

      assign proc_word = invert[gi] ? ~rot_word : rot_word;

      // HOLD drives zeros without post-processing.
      assign words_next[gi*WORD_WIDTH +: WORD_WIDTH] =
        (state_next == ST_HOLD) ? '0 : proc_word;
    end
  endgenerate

`ifndef TMDS_LANE_STAGE_SLIP_EN
  // Slip inputs have no function in this build.
  logic slip_unused;
  assign slip_unused = slip_req ^ (^slip_lane);
`endif

  // ---------------------------------------------------------------------------
  // State and output registers (outputs registered together with the state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= ST_HOLD;
      count_reg     <= '0;
      words_reg     <= '0;
      ser_reset_reg <= 1'b1;
      link_up_reg   <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      words_reg     <= words_next;
      ser_reset_reg <= (state_next == ST_HOLD);
      link_up_reg   <= (state_next == ST_RUN);
      underflow_reg <= underflow_next;
    end
  end

  assign out_words = words_reg;
  assign ser_reset = ser_reset_reg;
  assign link_up   = link_up_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_tmds_lane_stage.sv
// -----------------------------------------------------------------------------
// tb_tmds_lane_stage
//
// Directed bench for tmds_lane_stage with default parameters (4 lanes, 10-bit
// words, 16 hold cycles, 1024 training cycles). Walks through reset, start-up
// sequencing, live data, underflow substitution, inversion, bit-slip, lock loss
// and reset during activity. Expected words are hand-computed constants.
// Slip expectations follow the TMDS_LANE_STAGE_SLIP_EN build setting.
// -----------------------------------------------------------------------------
module tb_tmds_lane_stage;

  localparam int NL = 4;
  localparam int WW = 10;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               pll_locked;
  logic [NL*WW-1:0]   in_words;
  logic               in_valid;
  logic               slip_req;
  logic [1:0]         slip_lane;
  logic [NL-1:0]      invert;
  logic [NL*WW-1:0]   out_words;
  logic               ser_reset;
  logic               link_up;
  logic               underflow;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  tmds_lane_stage dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .in_words   (in_words),
    .in_valid   (in_valid),
    .slip_req   (slip_req),
    .slip_lane  (slip_lane),
    .invert     (invert),
    .out_words  (out_words),
    .ser_reset  (ser_reset),
    .link_up    (link_up),
    .underflow  (underflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [NL*WW-1:0] pack(input logic [WW-1:0] l0, input logic [WW-1:0] l1,
                                            input logic [WW-1:0] l2, input logic [WW-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  logic [NL*WW-1:0] train_w;
  logic [NL*WW-1:0] live_a;
  logic [NL*WW-1:0] live_b;
  logic [WW-1:0]    exp_lane;

  initial begin
    train_w = pack(10'h01F, 10'h354, 10'h354, 10'h354);
    live_a  = pack(10'h3FF, 10'h155, 10'h2AA, 10'h01F);
    live_b  = pack(10'h123, 10'h045, 10'h3C3, 10'h200);

    reset_n    = 1'b0;
    pll_locked = 1'b1;
    in_words   = live_a;
    in_valid   = 1'b1;
    slip_req   = 1'b0;
    slip_lane  = 2'd0;
    invert     = '0;

    // Reset values
    run(2);
    check("rst_words", 64'(out_words), 64'(0));
    check("rst_ser_reset", 64'(ser_reset), 64'(1));
    check("rst_link_up", 64'(link_up), 64'(0));
    check("rst_underflow", 64'(underflow), 64'(0));

    // Start-up sequence
    reset_n = 1'b1;
    run(15);
    check("hold_last_ser_reset", 64'(ser_reset), 64'(1));
    check("hold_last_words", 64'(out_words), 64'(0));
    run(1);
    check("train_first_ser_reset", 64'(ser_reset), 64'(0));
    check("train_first_words", 64'(out_words), 64'(train_w));
    check("train_first_link_up", 64'(link_up), 64'(0));
    run(1023);
    check("train_last_link_up", 64'(link_up), 64'(0));
    check("train_last_words", 64'(out_words), 64'(train_w));
    run(1);
    check("run_first_link_up", 64'(link_up), 64'(1));
    check("run_first_words", 64'(out_words), 64'(live_a));
    check("run_first_underflow", 64'(underflow), 64'(0));

    // Live data, one-cycle latency
    in_words = live_b;
    run(1);
    check("run_live_b", 64'(out_words), 64'(live_b));

    // Underflow substitution and sticky flag
    in_valid = 1'b0;
    run(1);
    check("uflow_words", 64'(out_words), 64'(train_w));
    check("uflow_flag", 64'(underflow), 64'(1));
    in_valid = 1'b1;
    in_words = live_a;
    run(1);
    check("uflow_recover_words", 64'(out_words), 64'(live_a));
    check("uflow_sticky", 64'(underflow), 64'(1));

    // Inversion on lane 1
    invert   = 4'b0010;
    in_words = pack(10'h3FF, 10'h354, 10'h2AA, 10'h01F);
    run(1);
    check("invert_lane1", 64'(out_words), 64'(pack(10'h3FF, 10'h0AB, 10'h2AA, 10'h01F)));
    invert = '0;

    // Slip on lane 2: three consecutive pulses then seven more to wrap
    in_words  = pack(10'h3FF, 10'h155, 10'h001, 10'h01F);
    slip_lane = 2'd2;
    slip_req  = 1'b1;
    run(3);
`ifdef TMDS_LANE_STAGE_SLIP_EN
    exp_lane = 10'h100;
`else
    exp_lane = 10'h001;
`endif
    check("slip2_count2", 64'(out_words), 64'(pack(10'h3FF, 10'h155, exp_lane, 10'h01F)));
    slip_req = 1'b0;
    run(1);
`ifdef TMDS_LANE_STAGE_SLIP_EN
    exp_lane = 10'h080;
`else
    exp_lane = 10'h001;
`endif
    check("slip2_count3", 64'(out_words), 64'(pack(10'h3FF, 10'h155, exp_lane, 10'h01F)));
    slip_req = 1'b1;
    run(7);
`ifdef TMDS_LANE_STAGE_SLIP_EN
    exp_lane = 10'h002;
`else
    exp_lane = 10'h001;
`endif
    check("slip2_count9", 64'(out_words), 64'(pack(10'h3FF, 10'h155, exp_lane, 10'h01F)));
    slip_req = 1'b0;
    run(1);
    check("slip2_wrap", 64'(out_words), 64'(pack(10'h3FF, 10'h155, 10'h001, 10'h01F)));

    // Slip 1 on lane 1 combined with inversion: rotate first, then NOT
    in_words  = pack(10'h3FF, 10'h354, 10'h001, 10'h01F);
    invert    = 4'b0010;
    slip_lane = 2'd1;
    slip_req  = 1'b1;
    run(1);
    slip_req = 1'b0;
    run(1);
`ifdef TMDS_LANE_STAGE_SLIP_EN
    exp_lane = 10'h255;
`else
    exp_lane = 10'h0AB;
`endif
    check("slip1_invert", 64'(out_words), 64'(pack(10'h3FF, exp_lane, 10'h001, 10'h01F)));
    invert = '0;

    // Lock loss for one cycle in RUN, then full re-sequence
    pll_locked = 1'b0;
    run(1);
    check("lock_loss_words", 64'(out_words), 64'(0));
    check("lock_loss_ser_reset", 64'(ser_reset), 64'(1));
    check("lock_loss_link_up", 64'(link_up), 64'(0));
    check("lock_loss_underflow", 64'(underflow), 64'(1));
    pll_locked = 1'b1;
    run(15);
    check("relock_hold_ser_reset", 64'(ser_reset), 64'(1));
    run(1);
`ifdef TMDS_LANE_STAGE_SLIP_EN
    exp_lane = 10'h1AA;
`else
    exp_lane = 10'h354;
`endif
    check("relock_train_ser_reset", 64'(ser_reset), 64'(0));
    check("relock_train_words", 64'(out_words), 64'(pack(10'h01F, exp_lane, 10'h354, 10'h354)));
    run(1023);
    check("relock_train_last_link_up", 64'(link_up), 64'(0));
    run(1);
    check("relock_run_link_up", 64'(link_up), 64'(1));
    check("relock_run_words", 64'(out_words), 64'(pack(10'h3FF, exp_lane, 10'h001, 10'h01F)));
    check("relock_underflow_kept", 64'(underflow), 64'(1));

    // Reset coincident with slip request and lock loss
    reset_n    = 1'b0;
    slip_req   = 1'b1;
    slip_lane  = 2'd1;
    pll_locked = 1'b0;
    run(1);
    check("rst2_words", 64'(out_words), 64'(0));
    check("rst2_ser_reset", 64'(ser_reset), 64'(1));
    check("rst2_link_up", 64'(link_up), 64'(0));
    check("rst2_underflow", 64'(underflow), 64'(0));
    reset_n    = 1'b1;
    slip_req   = 1'b0;
    pll_locked = 1'b1;
    run(16);
    check("rst2_train_slip_cleared", 64'(out_words), 64'(train_w));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
